scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Sequences the 16x16 scan-pattern ROM for the RDOQ coefficient loop.
- On a start command it walks scan indices in forward or reverse order, up to a programmable last index.
- Drives the ROM address and scan type, and splits each ROM word into (x, y).
- Emits one coefficient position per accepted beat on a valid/ready stream to the RDOQ cost datapath. Reverse order is the normal RDOQ mode: last significant coefficient first.

Parameters:
- N_COEF, 256, coefficients per block; the scan index runs 0..N_COEF-1.
- IDX_W, 8, scan index width; must equal $clog2(N_COEF).
- POS_W, 9, ROM data width; bits [7:4] = x, bits [3:0] = y.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; honoured only in IDLE.
- scan_type_in  in  2  0=diag, 1=hor, 2=ver, 3 is treated as diag.
- last_idx  in  IDX_W  highest scan index to emit (inclusive).
- reverse  in  1  1: emit last_idx down to 0; 0: emit 0 up to last_idx.
- busy  out  1  high from the accepted start until the done pulse, inclusive.
- done  out  1  one-cycle pulse after the final beat is accepted.
- rom_scan_type  out  2  to the ROM scan_type input; latched value.
- rom_addr  out  IDX_W  to the ROM address input; current scan index.
- rom_data  in  POS_W  combinational ROM read data for rom_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_idx  out  IDX_W  scan index of the beat.
- out_x  out  4  rom_data[7:4], registered.
- out_y  out  4  rom_data[3:0], registered.
- out_last  out  1  marks the final beat of the block.

Behaviour:
- Reset: all of the following go to 0: state=IDLE, busy, done, out_valid, out_idx, out_x, out_y, out_last, rom_addr, rom_scan_type. Reset mid-run aborts with no done pulse.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start=1:
  - Latch scan_type_in (3 is stored as 0), reverse and last_idx.
  - Set cnt to last_idx if reverse, else 0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, register load:
  - rom_addr=cnt every cycle.
  - Load condition: !out_valid || out_ready.
  - On load: out_valid=1, out_idx=cnt, out_x/out_y from rom_data, out_last=(cnt==end), where end = 0 if reverse, else last_idx.
  - After a load, cnt steps by -1 (reverse) or +1 (forward).
  - A load with cnt==end goes to FLUSH.
- Throughput and latency:
  - Full throughput is one beat per clock.
  - Latency from start to first out_valid is 2 cycles: the start edge enters RUN, and the next edge loads the output register.
- FLUSH:
  - Wait for out_valid && out_ready on the last beat.
  - On that edge: out_valid=0, done=1 for one cycle, then IDLE.
  - busy drops together with the done pulse.
- Stream rules:
  - out_* must stay stable while out_valid && !out_ready.
  - out_valid must never drop without a handshake, except on rst.
- Edge cases:
  - last_idx=0: exactly one beat (idx 0, out_last=1).
  - last_idx=255: 256 beats; cnt never wraps, because the end compare is made before stepping.
  - start while busy is ignored; it is not queued.
  - A new start in the same cycle as done is ignored; the controller accepts start from IDLE, i.e. one cycle later.
- Inputs changing mid-run: scan_type_in, last_idx and reverse have no effect while busy; only the latched values are used.

Optional Feature:
- Macro: SCAN_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN or FLUSH forces out_valid=0 and returns to IDLE next cycle.
  - No done pulse; busy drops the same edge.
  - Also adds output aborted, a one-cycle pulse.
  - abort in IDLE is a no-op; abort wins over a same-cycle handshake.
- Undefined: neither port exists; behaviour is exactly as above.

Decomposition:
- Package scan_pkg:
  - typedef enum logic [1:0] scan_type_e {SCAN_DIAG, SCAN_HOR, SCAN_VER}.
  - typedef enum logic [1:0] seq_state_e {IDLE, RUN, FLUSH}.
  - localparams N_COEF=256, IDX_W=8, POS_W=9.
- The ROM stays external and the sequencer connects to it through ports.
- No sub-module; the FSM and output register live in one module.
- The bench instantiates the existing ROM alongside the DUT.

Test Plan:
- Diag forward: start, type 0, last_idx=2, reverse=0, out_ready=1 → beats (idx,x,y) = (0,0,0), (1,0,1), (2,1,0); out_last on idx 2; done one cycle after; busy spans 5 cycles.
- Vertical reverse: type 2, last_idx=17, reverse=1 → 18 beats; first (17,1,1), then (16,0,1), ..., last (0,0,0) with out_last=1.
- Backpressure: type 1, last_idx=255, out_ready toggling 1,0,0,1,… → all 256 idx emitted exactly once, in order; out_* stable during stalls; done after idx 255.
- Boundary and ignore rules: last_idx=0 → single beat, out_last=1; start reasserted while busy and in the done cycle → no extra beats; type 3 → rom_scan_type=0.
- Reset mid-run: rst after 5 beats → next cycle out_valid=0, busy=0, done=0; a fresh start runs normally.
- SCAN_ABORT_EN: abort during a stall at idx 40 → out_valid=0 next cycle, aborted pulse, no done; IDLE then accepts start.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared types and sizes for the RDOQ scan-position sequencer.
package scan_pkg;

  localparam int unsigned N_COEF = 256;
  localparam int unsigned IDX_W  = $clog2(N_COEF);
  localparam int unsigned POS_W  = 9;
  localparam int unsigned XY_W   = 4;

  typedef enum logic [1:0] {
    SCAN_DIAG = 2'd0,
    SCAN_HOR  = 2'd1,
    SCAN_VER  = 2'd2
  } scan_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_e;

  // Coefficient position as packed in the low byte of a ROM word.
  typedef struct packed {
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
  } pos_t;

  function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx,
                                                input logic             rev);
    return rev ? idx - IDX_W'(1) : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Coefficient-position stream from the scan sequencer to the RDOQ cost datapath.
interface scan_sequencer_if;
  import scan_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_idx;
  logic [XY_W-1:0]      out_x;
  logic [XY_W-1:0]      out_y;
  logic                 out_last;

  modport master (
    output out_valid, out_idx, out_x, out_y, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, out_x, out_y, out_last,
    output out_ready
  );
endinterface

// File: rtl/scan_sequencer.sv
// Walks the external scan-pattern ROM forward or in reverse and streams (idx, x, y).
// Optional SCAN_ABORT_EN adds an abort input and a one-cycle aborted pulse.
module scan_sequencer
  import scan_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           scan_type_in,
  input  logic [IDX_W-1:0]     last_idx,
  input  logic                 reverse,
`ifdef SCAN_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           rom_scan_type,
  output logic [IDX_W-1:0]     rom_addr,
  input  logic [POS_W-1:0]     rom_data,
  scan_sequencer_if.master     out_if
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  scan_type_e       scan_type_q, scan_type_d;
  logic             rev_q, rev_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  pos_t             out_pos_q, out_pos_d;
  logic             out_last_q, out_last_d;

  logic             start_acc_c;
  logic             load_c;
  logic             hs_c;
  logic             at_end_c;
  logic [IDX_W-1:0] end_idx_c;
  logic             abort_c;
  logic             unused_rom_msb;

  // busy_q is still high in the done cycle, so a start there is dropped.
  assign start_acc_c    = (state_q == IDLE) && !busy_q && start;
  assign load_c         = (state_q == RUN) && (!out_valid_q || out_if.out_ready);
  assign hs_c           = out_valid_q && out_if.out_ready;
  assign end_idx_c      = rev_q ? IDX_W'(0) : last_q;
  assign at_end_c       = (cnt_q == end_idx_c);
  assign unused_rom_msb = rom_data[POS_W-1];

`ifdef SCAN_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_c = abort && (state_q != IDLE);

  always_comb begin
    aborted_d = abort_c;
  end

  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= aborted_d;
  end

  assign aborted = aborted_q;
`else
  assign abort_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc_c)          state_d = RUN;
      RUN:     if (load_c && at_end_c)   state_d = FLUSH;
      FLUSH:   if (hs_c)                 state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d       = cnt_q;
    scan_type_d = scan_type_q;
    rev_d       = rev_q;
    last_d      = last_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_pos_d   = out_pos_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start_acc_c) begin
          scan_type_d = (scan_type_in == 2'd3) ? SCAN_DIAG : scan_type_e'(scan_type_in);
          rev_d       = reverse;
          last_d      = last_idx;
          cnt_d       = reverse ? last_idx : IDX_W'(0);
        end
      end
      RUN: begin
        if (load_c) begin
          out_valid_d = 1'b1;
          out_idx_d   = cnt_q;
          out_pos_d   = pos_t'(rom_data[2*XY_W-1:0]);
          out_last_d  = at_end_c;
          // Holding at the end index keeps a 0..255 walk from wrapping.
          if (!at_end_c) cnt_d = step_idx(cnt_q, rev_q);
        end
      end
      FLUSH: begin
        if (hs_c) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase

    if (abort_c) begin
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      scan_type_q <= SCAN_DIAG;
      rev_q       <= 1'b0;
      last_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_pos_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      scan_type_q <= scan_type_d;
      rev_q       <= rev_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_pos_q   <= out_pos_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rom_scan_type    = scan_type_q;
  assign rom_addr         = cnt_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_x     = out_pos_q.x;
  assign out_if.out_y     = out_pos_q.y;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer with a behavioural scan-pattern ROM.
// Define SCAN_ABORT_EN to also exercise the abort path.
module tb_scan_sequencer;

  typedef struct {
    logic [1:0] stype;
    logic [7:0] last;
    logic       rev;
    int         ready_mode;
    logic       poke;
    logic [7:0] f_idx;
    logic [3:0] f_x;
    logic [3:0] f_y;
    logic [1:0] rom_type;
    int         exp_busy;
  } vec_t;

  typedef struct {
    logic [7:0] idx;
    logic [3:0] x;
    logic [3:0] y;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] scan_type_in = 2'd0;
  logic [7:0] last_idx = 8'd0;
  logic       reverse = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done;
  logic [1:0] rom_scan_type;
  logic [7:0] rom_addr;
  logic [8:0] rom_data;
`ifdef SCAN_ABORT_EN
  logic       aborted;
`endif

  scan_sequencer_if sif ();

  scan_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .scan_type_in (scan_type_in),
    .last_idx     (last_idx),
    .reverse      (reverse),
`ifdef SCAN_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .busy         (busy),
    .done         (done),
    .rom_scan_type(rom_scan_type),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .out_if       (sif)
  );

  always #5 clk = ~clk;

  // Pattern ROM: diag walks anti-diagonals with x rising; bit 8 carries junk parity.
  function automatic logic [8:0] rom_lookup(input logic [1:0] t, input logic [7:0] a);
    logic [3:0] x, y;
    int k;
    x = 4'd0;
    y = 4'd0;
    case (t)
      2'd1: begin x = a[7:4]; y = a[3:0]; end
      2'd2: begin x = a[3:0]; y = a[7:4]; end
      default: begin
        k = 0;
        for (int d = 0; d < 31; d++)
          for (int i = 0; i < 16; i++)
            if (d - i >= 0 && d - i < 16) begin
              if (k == int'(a)) begin x = 4'(i); y = 4'(d - i); end
              k++;
            end
      end
    endcase
    return {^a, x, y};
  endfunction

  always_comb rom_data = rom_lookup(rom_scan_type, rom_addr);

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q[$];
  int    beat_cnt = 0;
  int    busy_cnt = 0;
  int    done_cnt = 0;
  logic [7:0] first_idx;
  logic [3:0] first_x, first_y;
  logic       stall_prev = 1'b0;
  beat_t      held;
  vec_t       vecs[7];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Stream monitor: scoreboard pops, stall stability, busy/done bookkeeping.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", int'(sif.out_valid), 1);
        check("stall_idx",   int'(sif.out_idx),  int'(held.idx));
        check("stall_x",     int'(sif.out_x),    int'(held.x));
        check("stall_y",     int'(sif.out_y),    int'(held.y));
        check("stall_last",  int'(sif.out_last), int'(held.last));
      end
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got idx %0d, required no beat", sif.out_idx);
        end else begin
          e = exp_q.pop_front();
          check("beat_idx",  int'(sif.out_idx),  int'(e.idx));
          check("beat_x",    int'(sif.out_x),    int'(e.x));
          check("beat_y",    int'(sif.out_y),    int'(e.y));
          check("beat_last", int'(sif.out_last), int'(e.last));
        end
        if (beat_cnt == 0) begin
          first_idx = sif.out_idx;
          first_x   = sif.out_x;
          first_y   = sif.out_y;
        end
        beat_cnt++;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      stall_prev = sif.out_valid && !sif.out_ready && !abort;
      held = '{sif.out_idx, sif.out_x, sif.out_y, sif.out_last};
    end
  end

  task automatic push_expected(input logic [1:0] stype, input logic [7:0] last, input logic rev);
    logic [1:0] eff;
    logic [7:0] i;
    logic [8:0] w;
    eff = (stype == 2'd3) ? 2'd0 : stype;
    for (int k = 0; k <= int'(last); k++) begin
      i = rev ? 8'(int'(last) - k) : 8'(k);
      w = rom_lookup(eff, i);
      exp_q.push_back('{i, w[7:4], w[3:0], k == int'(last)});
    end
  endtask

  task automatic run_case(input vec_t v);
    int cyc;
    beat_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; scan_type_in = v.stype; last_idx = v.last; reverse = v.rev;
    sif.out_ready = 1'b1;
    push_expected(v.stype, v.last, v.rev);
    @(posedge clk); #1;
    start = 1'b0;
    // Latched values must win over inputs that change mid-run.
    scan_type_in = ~v.stype; last_idx = v.last ^ 8'h5a; reverse = ~v.rev;
    check("rom_scan_type", int'(rom_scan_type), int'(v.rom_type));
    cyc = 0;
    while (cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      sif.out_ready = (v.ready_mode == 0) ? 1'b1 : (cyc % 3 == 1);
      if (v.poke) start = 1'b1;
      if (done) break;
    end
    if (cyc >= 4000) check("done_timeout", cyc, 0);
    @(posedge clk); #1;
    start = 1'b0;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("beats", beat_cnt, int'(v.last) + 1);
    check("left_in_queue", exp_q.size(), 0);
    check("first_idx", int'(first_idx), int'(v.f_idx));
    check("first_x", int'(first_x), int'(v.f_x));
    check("first_y", int'(first_y), int'(v.f_y));
    check("idle_valid", int'(sif.out_valid), 0);
    check("idle_busy", int'(busy), 0);
    if (v.exp_busy != 0) check("busy_cycles", busy_cnt, v.exp_busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    vecs[0] = '{2'd0, 8'd2,   1'b0, 0, 1'b0, 8'd0,   4'd0,  4'd0,  2'd0, 5};
    vecs[1] = '{2'd2, 8'd17,  1'b1, 0, 1'b0, 8'd17,  4'd1,  4'd1,  2'd2, 20};
    vecs[2] = '{2'd1, 8'd255, 1'b0, 1, 1'b0, 8'd0,   4'd0,  4'd0,  2'd1, 0};
    vecs[3] = '{2'd0, 8'd0,   1'b0, 0, 1'b0, 8'd0,   4'd0,  4'd0,  2'd0, 3};
    vecs[4] = '{2'd3, 8'd5,   1'b1, 0, 1'b1, 8'd5,   4'd2,  4'd0,  2'd0, 8};
    vecs[5] = '{2'd0, 8'd0,   1'b1, 1, 1'b1, 8'd0,   4'd0,  4'd0,  2'd0, 0};
    vecs[6] = '{2'd2, 8'd255, 1'b1, 1, 1'b0, 8'd255, 4'd15, 4'd15, 2'd2, 0};

    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(sif.out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(sif.out_idx), 0);
    check("rst_x", int'(sif.out_x), 0);
    check("rst_y", int'(sif.out_y), 0);
    check("rst_last", int'(sif.out_last), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_rom_type", int'(rom_scan_type), 0);
    rst = 1'b0;

    foreach (vecs[n]) run_case(vecs[n]);

    // Reset five beats into a horizontal run.
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; scan_type_in = 2'd1; last_idx = 8'd20; reverse = 1'b0;
    push_expected(2'd1, 8'd20, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (beat_cnt < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("rst_run_beats", beat_cnt, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", int'(sif.out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_rom_addr", int'(rom_addr), 0);
    check("midrst_rom_type", int'(rom_scan_type), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    run_case(vecs[0]);

`ifdef SCAN_ABORT_EN
    // Abort while idx 40 is stalled.
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; scan_type_in = 2'd1; last_idx = 8'd100; reverse = 1'b0;
    sif.out_ready = 1'b1;
    push_expected(2'd1, 8'd100, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (beat_cnt < 40 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    sif.out_ready = 1'b0;
    check("abort_stall_idx", int'(sif.out_idx), 40);
    @(posedge clk); #1;
    check("abort_stall_valid", int'(sif.out_valid), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", int'(sif.out_valid), 0);
    check("abort_pulse", int'(aborted), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk); #1;
    check("abort_pulse_end", int'(aborted), 0);
    check("abort_no_done", done_cnt, 0);
    exp_q.delete();
    sif.out_ready = 1'b1;
    run_case(vecs[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
